// File: rtl/fp_rf_pkg.sv
// Shared formats and access helpers for the FP register file (single/double pairing).
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package fp_rf_pkg;

    localparam logic [4:0] FMT_S = 5'h10;
    localparam logic [4:0] FMT_D = 5'h11;

    // Widest register file the helpers support; callers cast results down to NREG/AW.
    localparam int MAX_NREG = 256;
    localparam int ADDR_W   = $clog2(MAX_NREG);

    function automatic logic fmt_legal(input logic [4:0] fmt, input logic [ADDR_W-1:0] addr);
        return (fmt == FMT_S) || ((fmt == FMT_D) && !addr[0]);
    endfunction

    // Registers touched by an access: addr alone, or the even/odd pair for doubles.
    function automatic logic [MAX_NREG-1:0] pair_mask(input logic [4:0] fmt, input logic [ADDR_W-1:0] addr);
        logic [MAX_NREG-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        if (fmt == FMT_D) begin
            m[addr | ADDR_W'(1)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_regfile_sb_if.sv
// Read, write and reservation bus of the FP register file.
// Latency: n/a.  Backpressure: none, every request is accepted each cycle.
interface fp_regfile_sb_if #(
    parameter int NREG   = 32,
    parameter int WORD_W = 32,
    parameter int NRD    = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD-1:0]          rd_en;
    logic [NRD*AW-1:0]       rd_addr;
    logic [NRD*5-1:0]        rd_fmt;
    logic [NRD*2*WORD_W-1:0] rd_data;
    logic [NRD-1:0]          rd_busy;

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [4:0]              wr_fmt;
    logic [2*WORD_W-1:0]     wr_data;

    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic [4:0]              rsv_fmt;

    logic                    err;

    modport master (
        output rd_en, rd_addr, rd_fmt,
        output wr_en, wr_addr, wr_fmt, wr_data,
        output rsv_en, rsv_addr, rsv_fmt,
        input  rd_data, rd_busy, err
    );

    modport slave (
        input  rd_en, rd_addr, rd_fmt,
        input  wr_en, wr_addr, wr_fmt, wr_data,
        input  rsv_en, rsv_addr, rsv_fmt,
        output rd_data, rd_busy, err
    );
endinterface

// File: rtl/fp_rf_scoreboard.sv
// Busy-bit vector marking destinations of in-flight long-latency FP ops.
// Latency: set/clear visible on o_busy one cycle later, immediately on o_busy_nxt.
// Backpressure: none; a reservation on the same register as a clear wins.
module fp_rf_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] i_set_mask,
    input  logic [NREG-1:0] i_clr_mask,
    output logic [NREG-1:0] o_busy,
    output logic [NREG-1:0] o_busy_nxt
);

    logic [NREG-1:0] r_busy;

    assign o_busy_nxt = (r_busy & ~i_clr_mask) | i_set_mask;
    assign o_busy     = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= o_busy_nxt;
        end
    end

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file: NRD registered read ports, one write port, S/D pairing, busy scoreboard; FP_RF_BYPASS_EN forwards same-edge writes/reservations.
// Latency: reads 1 cycle; writes and reservations take effect at the sampling edge.
// Backpressure: none; illegal accesses are dropped and raise the sticky err flag.
module fp_regfile_sb
    import fp_rf_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int WORD_W = 32,
    parameter int NRD    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_regfile_sb_if.slave bus
);

    localparam int AW = $clog2(NREG);

`ifdef FP_RF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [WORD_W-1:0] r_regs     [NREG];
    logic [WORD_W-1:0] w_reg_nxt  [NREG];
    logic [WORD_W-1:0] w_src_regs [NREG];

    logic [NREG-1:0] w_wr_mask;
    logic [NREG-1:0] w_rsv_mask;
    logic [NREG-1:0] w_busy_q;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] w_src_busy;

    logic            w_wr_legal;
    logic            w_rsv_legal;
    logic            w_wr_is_d;
    logic [NRD-1:0]  w_rd_bad;
    logic            r_err;

    assign w_wr_legal  = fmt_legal(bus.wr_fmt, ADDR_W'(bus.wr_addr));
    assign w_rsv_legal = fmt_legal(bus.rsv_fmt, ADDR_W'(bus.rsv_addr));
    assign w_wr_is_d   = (bus.wr_fmt == FMT_D);

    assign w_wr_mask  = (bus.wr_en && w_wr_legal)
                      ? NREG'(pair_mask(bus.wr_fmt, ADDR_W'(bus.wr_addr))) : '0;
    assign w_rsv_mask = (bus.rsv_en && w_rsv_legal)
                      ? NREG'(pair_mask(bus.rsv_fmt, ADDR_W'(bus.rsv_addr))) : '0;

    // Odd half of a double write takes the high word; everything else the low word.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_reg_nxt[i] = r_regs[i];
            if (w_wr_mask[i]) begin
                w_reg_nxt[i] = (w_wr_is_d && i[0]) ? bus.wr_data[2*WORD_W-1:WORD_W]
                                                   : bus.wr_data[WORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= w_reg_nxt[i];
            end
        end
    end

    fp_rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_mask (w_rsv_mask),
        .i_clr_mask (w_wr_mask),
        .o_busy     (w_busy_q),
        .o_busy_nxt (w_busy_nxt)
    );

    // Read source: post-edge state when forwarding, pre-edge state otherwise.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_src_regs[i] = BYPASS_EN ? w_reg_nxt[i] : r_regs[i];
        end
    end
    assign w_src_busy = BYPASS_EN ? w_busy_nxt : w_busy_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]       w_addr;
        logic [AW-1:0]       w_addr_hi;
        logic [4:0]          w_fmt;
        logic                w_legal;
        logic                w_is_d;
        logic [WORD_W-1:0]   w_lo;
        logic [WORD_W-1:0]   w_hi;
        logic                w_busy;
        logic [2*WORD_W-1:0] r_data;
        logic                r_busy;

        assign w_addr    = bus.rd_addr[p*AW +: AW];
        assign w_fmt     = bus.rd_fmt[p*5 +: 5];
        assign w_legal   = fmt_legal(w_fmt, ADDR_W'(w_addr));
        assign w_is_d    = (w_fmt == FMT_D);
        assign w_addr_hi = w_addr | AW'(1);

        assign w_lo   = w_src_regs[w_addr];
        assign w_hi   = w_is_d ? w_src_regs[w_addr_hi] : '0;
        assign w_busy = w_src_busy[w_addr] | (w_is_d & w_src_busy[w_addr_hi]);

        assign w_rd_bad[p] = bus.rd_en[p] & ~w_legal;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= '0;
                r_busy <= 1'b0;
            end else if (bus.rd_en[p]) begin
                if (w_legal) begin
                    r_data <= {w_hi, w_lo};
                    r_busy <= w_busy;
                end else begin
                    r_data <= '0;
                    r_busy <= 1'b0;
                end
            end
        end

        assign bus.rd_data[p*2*WORD_W +: 2*WORD_W] = r_data;
        assign bus.rd_busy[p]                      = r_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((bus.wr_en && !w_wr_legal) || (bus.rsv_en && !w_rsv_legal) || (|w_rd_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Scoreboard bench for fp_regfile_sb: directed plan items plus a random mix, both bypass builds.
module tb_fp_regfile_sb;

    localparam logic [4:0] S   = 5'h10;
    localparam logic [4:0] D   = 5'h11;
`ifdef FP_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic        b;
    } exp_t;

    logic clk;
    logic rst_n;

    fp_regfile_sb_if #(.NREG(32), .WORD_W(32), .NRD(2)) bus ();

    fp_regfile_sb #(.NREG(32), .WORD_W(32), .NRD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_err;
    exp_t        last_rd [2];
    exp_t        exp_q [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic legal(input logic [4:0] f, input logic [4:0] a);
        return (f == S) || (f == D && a[0] == 1'b0);
    endfunction

    function automatic exp_t rd_model(input logic [4:0] f, input logic [4:0] a,
                                      input logic [31:0] regs [32], input logic [31:0] bsy);
        exp_t e;
        logic [4:0] ah;
        ah = a | 5'd1;
        e  = '0;
        if (f == S) begin
            e.d = {32'h0, regs[a]};
            e.b = bsy[a];
        end else if (f == D && a[0] == 1'b0) begin
            e.d = {regs[ah], regs[a]};
            e.b = bsy[a] | bsy[ah];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic idle();
        bus.rd_en  = '0;
        bus.wr_en  = 1'b0;
        bus.rsv_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] f, input logic [4:0] a);
        bus.rd_en[p]          = 1'b1;
        bus.rd_fmt[p*5 +: 5]  = f;
        bus.rd_addr[p*5 +: 5] = a;
    endtask

    task automatic set_wr(input logic [4:0] f, input logic [4:0] a, input logic [63:0] dat);
        bus.wr_en   = 1'b1;
        bus.wr_fmt  = f;
        bus.wr_addr = a;
        bus.wr_data = dat;
    endtask

    task automatic set_rsv(input logic [4:0] f, input logic [4:0] a);
        bus.rsv_en   = 1'b1;
        bus.rsv_fmt  = f;
        bus.rsv_addr = a;
    endtask

    // Predict the edge from the current inputs, clock it, then compare both ports and err.
    task automatic step();
        logic [31:0] n_regs [32];
        logic [31:0] n_busy;
        logic [4:0]  f;
        logic [4:0]  a;
        exp_t        e;
        n_regs = m_regs;
        n_busy = m_busy;
        if (bus.rsv_en) begin
            if (!legal(bus.rsv_fmt, bus.rsv_addr)) m_err = 1'b1;
        end
        if (bus.wr_en) begin
            if (legal(bus.wr_fmt, bus.wr_addr)) begin
                if (bus.wr_fmt == D) begin
                    n_regs[bus.wr_addr]     = bus.wr_data[31:0];
                    n_regs[bus.wr_addr + 1] = bus.wr_data[63:32];
                    n_busy[bus.wr_addr]     = 1'b0;
                    n_busy[bus.wr_addr + 1] = 1'b0;
                end else begin
                    n_regs[bus.wr_addr] = bus.wr_data[31:0];
                    n_busy[bus.wr_addr] = 1'b0;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (bus.rsv_en && legal(bus.rsv_fmt, bus.rsv_addr)) begin
            n_busy[bus.rsv_addr] = 1'b1;
            if (bus.rsv_fmt == D) n_busy[bus.rsv_addr + 1] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            f = bus.rd_fmt[p*5 +: 5];
            a = bus.rd_addr[p*5 +: 5];
            if (bus.rd_en[p]) begin
                if (!legal(f, a)) m_err = 1'b1;
                e = BYP ? rd_model(f, a, n_regs, n_busy) : rd_model(f, a, m_regs, m_busy);
                last_rd[p] = e;
            end
            exp_q.push_back(last_rd[p]);
        end
        @(posedge clk);
        m_regs = n_regs;
        m_busy = n_busy;
        #1;
        for (int p = 0; p < 2; p++) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("rd_data%0d", p), bus.rd_data[p*64 +: 64], e.d);
                chk($sformatf("rd_busy%0d", p), 64'(bus.rd_busy[p]), 64'(e.b));
            end
        end
        chk("err", 64'(bus.err), 64'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_d0"}, bus.rd_data[63:0], 64'h0);
        chk({tag, "_d1"}, bus.rd_data[127:64], 64'h0);
        chk({tag, "_busy"}, 64'(bus.rd_busy), 64'h0);
        chk({tag, "_err"}, 64'(bus.err), 64'h0);
    endtask

    initial begin
        logic [4:0] f;
        logic [4:0] a;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.rd_addr = '0; bus.rd_fmt = {S, S};
        bus.wr_addr = '0; bus.wr_fmt = S; bus.wr_data = '0;
        bus.rsv_addr = '0; bus.rsv_fmt = S;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) begin
            idle();
            set_rd(0, S, 5'(i));
            set_rd(1, S, 5'(31 - i));
            step();
        end

        idle(); set_wr(D, 5'd4, 64'hAAAA_BBBB_CCCC_DDDD); step();
        idle(); set_rd(0, D, 5'd4); set_rd(1, S, 5'd5); step();
        chk("d4_pair", bus.rd_data[63:0], 64'hAAAA_BBBB_CCCC_DDDD);
        chk("s5_high", bus.rd_data[127:64], 64'h0000_0000_AAAA_BBBB);

        idle(); set_rsv(D, 5'd8); step();
        idle(); set_rd(0, S, 5'd9); step();
        chk("rsv9_busy", 64'(bus.rd_busy[0]), 64'd1);
        idle(); set_wr(D, 5'd8, 64'h1111_2222_3333_4444); set_rd(0, S, 5'd9); step();
        chk("wr8_same_busy", 64'(bus.rd_busy[0]), BYP ? 64'd0 : 64'd1);
        idle(); set_rd(0, S, 5'd9); step();
        chk("wr8_next_busy", 64'(bus.rd_busy[0]), 64'd0);

        idle(); set_wr(S, 5'd3, 64'h1234_5678); set_rd(0, S, 5'd3); step();
        chk("s3_same", bus.rd_data[63:0], BYP ? 64'h1234_5678 : 64'h0);
        idle(); set_rd(0, S, 5'd3); step();
        chk("s3_next", bus.rd_data[63:0], 64'h1234_5678);

        idle(); set_wr(S, 5'd3, 64'hDEAD_BEEF); set_rd(1, D, 5'd2); step();

        idle(); set_wr(D, 5'd6, 64'h7777_7777_6666_6666); set_rsv(S, 5'd7); step();
        idle(); set_wr(D, 5'd7, 64'hFFFF_FFFF_EEEE_EEEE); step();
        chk("odd_d_err", 64'(bus.err), 64'd1);
        idle(); set_rd(0, S, 5'd7); set_rd(1, S, 5'd8); step();
        chk("odd_d_r7", bus.rd_data[63:0], 64'h7777_7777);
        chk("odd_d_b7", 64'(bus.rd_busy[0]), 64'd1);
        idle(); set_rd(0, 5'h14, 5'd6); set_rd(1, D, 5'd9); step();
        repeat (3) begin idle(); step(); end

        idle(); set_rsv(S, 5'd2); set_wr(S, 5'd2, 64'h0BAD_F00D); step();
        idle(); set_rd(0, S, 5'd2); step();
        chk("rsv_wr2_busy", 64'(bus.rd_busy[0]), 64'd1);
        chk("rsv_wr2_data", bus.rd_data[63:0], 64'h0BAD_F00D);

        for (int n = 0; n < 300; n++) begin
            idle();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    f = ($urandom_range(0, 29) == 0) ? 5'h00 : ($urandom_range(0, 1) ? S : D);
                    a = 5'($urandom_range(0, 31));
                    if (f == D && $urandom_range(0, 7) != 0) a[0] = 1'b0;
                    set_rd(p, f, a);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                a = 5'($urandom_range(0, 31));
                f = $urandom_range(0, 1) ? S : D;
                if (f == D) a[0] = 1'b0;
                set_wr(f, a, {$urandom, $urandom});
            end
            if ($urandom_range(0, 3) == 0) begin
                a = 5'($urandom_range(0, 31));
                f = $urandom_range(0, 1) ? S : D;
                if (f == D) a[0] = 1'b0;
                set_rsv(f, a);
            end
            step();
        end

        idle(); set_rsv(D, 5'd10); step();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        idle(); set_rd(0, D, 5'd10); set_rd(1, S, 5'd4); step();
        chk("midreset_b10", 64'(bus.rd_busy[0]), 64'd0);
        chk("midreset_r4", bus.rd_data[127:64], 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
